// File: rtl/robot_fsm_sequencer_pkg.sv
// Shared state encodings for the robot motion sequencer and the motor output decoder.
// Also holds a helper that identifies the states governed by the dwell timer.
package robot_fsm_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FORWARD  = 3'd1,
        ST_BACKWARD = 3'd2,
        ST_LEFT     = 3'd3,
        ST_RIGHT    = 3'd4,
        ST_STOP     = 3'd5,
        ST_ERROR    = 3'd6,
        ST_RECOVER  = 3'd7
    } state_e;

    localparam logic [7:0] OBSTACLE_MAX = 8'hFF;

    function automatic logic is_timed(input state_e s);
        logic w_timed;
        case (s)
            ST_BACKWARD, ST_LEFT, ST_RIGHT, ST_RECOVER: w_timed = 1'b1;
            default:                                    w_timed = 1'b0;
        endcase
        return w_timed;
    endfunction

    function automatic logic is_moving(input state_e s);
        logic w_moving;
        case (s)
            ST_FORWARD, ST_BACKWARD, ST_LEFT, ST_RIGHT, ST_RECOVER: w_moving = 1'b1;
            default:                                                w_moving = 1'b0;
        endcase
        return w_moving;
    endfunction

endpackage

// File: rtl/robot_fsm_sequencer_dwell_timer.sv
// Dwell down-counter: loaded with N-1 on entry to a timed state, done when it reaches zero.
module robot_dwell_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       enable,
    output logic       done
);

    logic [7:0] r_count;

    // Counter register: a load wins over counting down; the count rests at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (load) begin
            r_count <= load_value;
        end else if (enable && (r_count != 8'd0)) begin
            r_count <= r_count - 8'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign done = (r_count == 8'd0);

endmodule

// File: rtl/robot_fsm_sequencer.sv
// Robot motion sequencer: forward/avoid/turn/stop/error/recover state machine with
// timed dwells, a sticky error flag and a saturating front-obstacle counter.
module robot_fsm_sequencer
    import robot_fsm_sequencer_pkg::*;
#(
    parameter int BACK_CYCLES    = 4,
    parameter int TURN_CYCLES    = 8,
    parameter int RECOVER_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop_cmd,
    input  logic       obstacle_front,
    input  logic       obstacle_left,
    input  logic       obstacle_right,
    input  logic       fault,
    input  logic       clear_fault,
    output logic [2:0] state,
    output logic       error_flag,
    output logic [7:0] obstacle_count
);

    localparam logic [7:0] BACK_LOAD    = 8'(BACK_CYCLES - 1);
    localparam logic [7:0] TURN_LOAD    = 8'(TURN_CYCLES - 1);
    localparam logic [7:0] RECOVER_LOAD = 8'(RECOVER_CYCLES - 1);

    state_e     r_state;
    state_e     w_next;
    logic       r_error_flag;
    logic [7:0] r_obstacle_count;
    logic       w_done;
    logic       w_load;
    logic [7:0] w_load_value;
    logic       w_enable;
    logic       w_inc_obstacle;
    logic       w_set_error;
    logic       w_clr_error;

    robot_dwell_timer u_dwell (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load),
        .load_value (w_load_value),
        .enable     (w_enable),
        .done       (w_done)
    );

    // State and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_error_flag     <= 1'b0;
            r_obstacle_count <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_set_error) begin
                r_error_flag <= 1'b1;
            end else if (w_clr_error) begin
                r_error_flag <= 1'b0;
            end else begin
                r_error_flag <= r_error_flag;
            end
            if (w_inc_obstacle && (r_obstacle_count != OBSTACLE_MAX)) begin
                r_obstacle_count <= r_obstacle_count + 8'd1;
            end else begin
                r_obstacle_count <= r_obstacle_count;
            end
        end
    end

    // Next-state logic: fault outranks stop_cmd, which outranks the per-state rule.
    always_comb begin
        w_next = r_state;
        if (fault && (r_state != ST_ERROR)) begin
            w_next = ST_ERROR;
        end else if (stop_cmd && is_moving(r_state)) begin
            w_next = ST_STOP;
        end else begin
            case (r_state)
                ST_IDLE:     w_next = start ? ST_FORWARD : ST_IDLE;
                ST_FORWARD:  w_next = obstacle_front ? ST_BACKWARD : ST_FORWARD;
                ST_BACKWARD: begin
                    if (!w_done) begin
                        w_next = ST_BACKWARD;
                    end else if (!obstacle_left) begin
                        w_next = ST_LEFT;
                    end else if (!obstacle_right) begin
                        w_next = ST_RIGHT;
                    end else begin
                        w_next = ST_STOP;
                    end
                end
                ST_LEFT:     w_next = w_done ? ST_FORWARD : ST_LEFT;
                ST_RIGHT:    w_next = w_done ? ST_FORWARD : ST_RIGHT;
                ST_STOP:     w_next = (start && !stop_cmd) ? ST_FORWARD : ST_STOP;
                ST_ERROR:    w_next = (clear_fault && !fault) ? ST_RECOVER : ST_ERROR;
                ST_RECOVER:  w_next = w_done ? ST_IDLE : ST_RECOVER;
                default:     w_next = r_state;
            endcase
        end
    end

    // Control strobes derived from the current/next state pair.
    always_comb begin
        w_enable       = is_timed(r_state);
        w_load         = is_timed(w_next) && (w_next != r_state);
        w_inc_obstacle = (r_state == ST_FORWARD) && (w_next == ST_BACKWARD);
        w_set_error    = (w_next == ST_ERROR) && (r_state != ST_ERROR);
        w_clr_error    = (r_state == ST_RECOVER) && (w_next == ST_IDLE);
        case (w_next)
            ST_BACKWARD:       w_load_value = BACK_LOAD;
            ST_LEFT, ST_RIGHT: w_load_value = TURN_LOAD;
            ST_RECOVER:        w_load_value = RECOVER_LOAD;
            default:           w_load_value = 8'd0;
        endcase
    end

    assign state          = r_state;
    assign error_flag     = r_error_flag;
    assign obstacle_count = r_obstacle_count;

endmodule
